// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM array controller: default geometry,
// the access counter width and the controller state encoding.
package sram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/sram_ctrl_addr_decoder.sv
// Binary-to-one-hot wordline decoder. With en low the output is all-zero,
// so at most one bit is ever set.
module addr_decoder
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [(2**ADDR_W)-1:0] onehot
);

    // Raise exactly the bit selected by addr while enabled, nothing otherwise
    always_comb begin
        onehot = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// SRAM array controller: accepts one read or write request at a time and
// sequences the array through SETUP, ACCESS (wordline pulse of
// ACCESS_CYCLES cycles) and HOLD, then returns read data in RESP.
// All array-facing outputs are registered, so the async reset clears the
// wordline immediately.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   arr_rw,
    output logic [(2**ADDR_W)-1:0] arr_wordline,
    output logic [DATA_W-1:0]      arr_wdata,
    input  logic [DATA_W-1:0]      arr_bitlines
);

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_W-1:0]       addr_r;
    logic                    we_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [DATA_W-1:0]       rsp_rdata_r;
    logic                    arr_rw_r;
    logic [(2**ADDR_W)-1:0]  arr_wordline_r;
    logic [DATA_W-1:0]       arr_wdata_r;
    logic                    wl_en_s;
    logic [(2**ADDR_W)-1:0]  wl_next_s;

    // Wordline is active in the next cycle when entering or staying in ACCESS
    always_comb begin
        wl_en_s = 1'b0;
        if (state_r == ST_SETUP) begin
            wl_en_s = 1'b1;
        end else if ((state_r == ST_ACCESS) && (cnt_r != CNT_W'(0))) begin
            wl_en_s = 1'b1;
        end else begin
            wl_en_s = 1'b0;
        end
    end

    addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_addr_decoder (
        .addr   (addr_r),
        .en     (wl_en_s),
        .onehot (wl_next_s)
    );

    // Controller FSM with registered handshake and array outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            addr_r         <= '0;
            we_r           <= 1'b0;
            req_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= '0;
            arr_rw_r       <= 1'b0;
            arr_wordline_r <= '0;
            arr_wdata_r    <= '0;
        end else begin
            arr_wordline_r <= wl_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        addr_r      <= req_addr;
                        we_r        <= req_we;
                        arr_rw_r    <= req_we;
                        arr_wdata_r <= req_we ? req_wdata : '0;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_r   <= CNT_W'(ACCESS_CYCLES - 1);
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt_r == CNT_W'(0)) begin
                        // Bitlines are still driven by the closing wordline pulse
                        if (!we_r) begin
                            rsp_rdata_r <= arr_bitlines;
                        end
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    arr_rw_r <= 1'b0;
                    if (we_r) begin
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    arr_rw_r    <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign arr_rw       = arr_rw_r;
    assign arr_wordline = arr_wordline_r;
    assign arr_wdata    = arr_wdata_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three controllers (ACCESS_CYCLES 2, 1, 4), each on
// its own 8x8 grid array model, checked cycle by cycle against a reference
// memory and the timing rules of the controller.
module tb_sram_ctrl;

    localparam int NDUT = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid    [NDUT];
    logic       req_ready    [NDUT];
    logic       req_we       [NDUT];
    logic [2:0] req_addr     [NDUT];
    logic [7:0] req_wdata    [NDUT];
    logic       rsp_valid    [NDUT];
    logic       rsp_ready    [NDUT];
    logic [7:0] rsp_rdata    [NDUT];
    logic       arr_rw       [NDUT];
    logic [7:0] arr_wordline [NDUT];
    logic [7:0] arr_wdata    [NDUT];

    logic [7:0] exp_mem [NDUT][8];
    int         err_cnt    = 0;
    int         chk_cnt    = 0;
    int         onehot_bad = 0;
    int         last_wait;
    logic       chain_en = 1'b0;
    logic       chain_we;
    logic [2:0] chain_a;
    logic [7:0] chain_d;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int AC = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
        logic [7:0] bl_s;
        logic [7:0] mem_q [8] = '{default: 8'h00};

        sram_ctrl #(
            .DATA_W        (8),
            .ADDR_W        (3),
            .ACCESS_CYCLES (AC)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid[k]),
            .req_ready    (req_ready[k]),
            .req_we       (req_we[k]),
            .req_addr     (req_addr[k]),
            .req_wdata    (req_wdata[k]),
            .rsp_valid    (rsp_valid[k]),
            .rsp_ready    (rsp_ready[k]),
            .rsp_rdata    (rsp_rdata[k]),
            .arr_rw       (arr_rw[k]),
            .arr_wordline (arr_wordline[k]),
            .arr_wdata    (arr_wdata[k]),
            .arr_bitlines (bl_s)
        );

        // Grid array: every row with its wordline up stores the input word
        always @(posedge clk) begin
            for (int r = 0; r < 8; r++) begin
                if (arr_wordline[k][r] && arr_rw[k]) mem_q[r] <= arr_wdata[k];
            end
        end

        // Grid array: selected rows drive the shared bitlines on reads
        always_comb begin
            bl_s = 8'h00;
            for (int r = 0; r < 8; r++) begin
                if (arr_wordline[k][r] && !arr_rw[k]) bl_s = bl_s | mem_q[r];
            end
        end
    end

    // Count any cycle in which a wordline carries more than one set bit
    always @(negedge clk) begin
        int bad_now;
        bad_now = 0;
        for (int k = 0; k < NDUT; k++) begin
            if ($countones(arr_wordline[k]) > 1) bad_now = bad_now + 1;
        end
        onehot_bad <= onehot_bad + bad_now;
    end

    function automatic int acs(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on controller k, entered and left at posedge+1
    task automatic do_op(input int k, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input int stall);
        int         ac;
        int         n;
        logic [7:0] wl_e;
        logic [7:0] rd_e;
        ac   = acs(k);
        wl_e = 8'h01 << a;
        rd_e = exp_mem[k][a];
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        rsp_ready[k] = (stall == 0);
        n = 0;
        while (!req_ready[k] && (n < 50)) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        last_wait = n;
        check_val("accept_ready", {31'd0, req_ready[k]}, 32'd1);
        @(posedge clk); #1;
        if (chain_en) begin
            req_we[k]    = chain_we;
            req_addr[k]  = chain_a;
            req_wdata[k] = chain_d;
        end else begin
            req_valid[k] = 1'b0;
            req_addr[k]  = 3'($urandom_range(0, 7));
            req_wdata[k] = 8'($urandom_range(0, 255));
        end
        check_val("setup_wl", {24'd0, arr_wordline[k]}, 32'd0);
        check_val("setup_rw", {31'd0, arr_rw[k]}, {31'd0, we});
        check_val("setup_wdata", {24'd0, arr_wdata[k]}, we ? {24'd0, d} : 32'd0);
        check_val("setup_ready", {31'd0, req_ready[k]}, 32'd0);
        for (int c = 0; c < ac; c++) begin
            @(posedge clk); #1;
            check_val("access_wl", {24'd0, arr_wordline[k]}, {24'd0, wl_e});
            check_val("access_rw", {31'd0, arr_rw[k]}, {31'd0, we});
            check_val("access_wdata", {24'd0, arr_wdata[k]}, we ? {24'd0, d} : 32'd0);
            check_val("access_ready", {31'd0, req_ready[k]}, 32'd0);
        end
        @(posedge clk); #1;
        check_val("hold_wl", {24'd0, arr_wordline[k]}, 32'd0);
        check_val("hold_rw", {31'd0, arr_rw[k]}, {31'd0, we});
        check_val("hold_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
        @(posedge clk); #1;
        if (we) begin
            exp_mem[k][a] = d;
            check_val("wr_done_ready", {31'd0, req_ready[k]}, 32'd1);
            check_val("wr_no_rsp", {31'd0, rsp_valid[k]}, 32'd0);
            check_val("idle_rw", {31'd0, arr_rw[k]}, 32'd0);
            check_val("idle_wdata_held", {24'd0, arr_wdata[k]}, {24'd0, d});
        end else begin
            check_val("resp_valid", {31'd0, rsp_valid[k]}, 32'd1);
            check_val("resp_rdata", {24'd0, rsp_rdata[k]}, {24'd0, rd_e});
            check_val("resp_ready", {31'd0, req_ready[k]}, 32'd0);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check_val("stall_valid", {31'd0, rsp_valid[k]}, 32'd1);
                check_val("stall_rdata", {24'd0, rsp_rdata[k]}, {24'd0, rd_e});
                check_val("stall_ready", {31'd0, req_ready[k]}, 32'd0);
            end
            rsp_ready[k] = 1'b1;
            @(posedge clk); #1;
            check_val("rsp_done_valid", {31'd0, rsp_valid[k]}, 32'd0);
            check_val("rsp_done_ready", {31'd0, req_ready[k]}, 32'd1);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 3'd0;
            req_wdata[k] = 8'd0;
            rsp_ready[k] = 1'b1;
            for (int a = 0; a < 8; a++) exp_mem[k][a] = 8'h00;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < NDUT; k++) begin
            check_val("rst_wl", {24'd0, arr_wordline[k]}, 32'd0);
            check_val("rst_rw", {31'd0, arr_rw[k]}, 32'd0);
            check_val("rst_wdata", {24'd0, arr_wdata[k]}, 32'd0);
            check_val("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
            check_val("rst_rdata", {24'd0, rsp_rdata[k]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NDUT; k++) check_val("post_rst_ready", {31'd0, req_ready[k]}, 32'd1);

        // Basic write then read of word 0
        do_op(0, 1'b1, 3'd0, 8'd42, 0);
        do_op(0, 1'b0, 3'd0, 8'd17, 0);

        // Sparse writes, then read the whole array
        do_op(0, 1'b1, 3'd1, 8'd255, 0);
        do_op(0, 1'b1, 3'd3, 8'd69, 0);
        do_op(0, 1'b1, 3'd7, 8'd127, 0);
        for (int a = 0; a < 8; a++) do_op(0, 1'b0, 3'(a), 8'($urandom_range(0, 255)), 0);

        // Consumer back-pressure on a read
        do_op(0, 1'b0, 3'd3, 8'd0, 3);

        // Request held during a write is taken right at the cycle-5 edge
        chain_en = 1'b1;
        chain_we = 1'b1;
        chain_a  = 3'd2;
        chain_d  = 8'h5a;
        do_op(0, 1'b1, 3'd4, 8'hc3, 0);
        chain_en = 1'b0;
        do_op(0, 1'b1, 3'd2, 8'h5a, 0);
        check_val("chain_no_wait", 32'(last_wait), 32'd0);
        do_op(0, 1'b0, 3'd2, 8'd0, 0);
        do_op(0, 1'b0, 3'd4, 8'd0, 0);

        // Reset in the second ACCESS cycle of a write
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 3'd6;
        req_wdata[0] = 8'ha5;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("abort_pre_wl", {24'd0, arr_wordline[0]}, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_wl", {24'd0, arr_wordline[0]}, 32'd0);
        check_val("abort_rw", {31'd0, arr_rw[0]}, 32'd0);
        check_val("abort_wdata", {24'd0, arr_wdata[0]}, 32'd0);
        check_val("abort_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check_val("abort_rdata", {24'd0, rsp_rdata[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("abort_release_ready", {31'd0, req_ready[0]}, 32'd1);
        do_op(0, 1'b1, 3'd6, 8'h3c, 0);
        do_op(0, 1'b0, 3'd6, 8'd0, 0);

        // Randomized traffic on the default controller
        for (int i = 0; i < 24; i++) begin
            do_op(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        // Other pulse widths: same flow, timings scaled
        for (int k = 1; k < NDUT; k++) begin
            do_op(k, 1'b1, 3'd0, 8'd42, 0);
            do_op(k, 1'b0, 3'd0, 8'd0, 1);
            for (int i = 0; i < 8; i++) begin
                do_op(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            end
        end

        @(posedge clk); #1;
        check_val("wordline_onehot", 32'(onehot_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; array depth is 2**ADDR_W words.
REQ-003 Parameter ACCESS_CYCLES, default 2, number of cycles the wordline is held; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  target word index.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer accepts the read data.
REQ-013 rsp_rdata  output  DATA_W  read data.
REQ-014 arr_rw  output  1  array read/write select, 1 = write.
REQ-015 arr_wordline  output  2**ADDR_W  one-hot array wordline.
REQ-016 arr_wdata  output  DATA_W  array input word.
REQ-017 arr_bitlines  input  DATA_W  array bitline output.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-020 On accept, the controller SHALL register addr, we and wdata, then go IDLE->SETUP.
REQ-021 In SETUP (1 cycle): arr_rw=we and arr_wdata=wdata (0 for reads) driven; arr_wordline=0.
REQ-022 In ACCESS (ACCESS_CYCLES cycles, down-counter): arr_wordline SHALL be one-hot at the registered addr, arr_rw and arr_wdata held.
REQ-023 arr_wordline SHALL be all-zero in every state except ACCESS, and SHALL never carry more than one bit set.
REQ-024 For reads, arr_bitlines SHALL be sampled into rsp_rdata on the edge that ends the last ACCESS cycle.
REQ-025 In HOLD (1 cycle): arr_wordline=0, arr_rw and arr_wdata held; then write->IDLE, read->RESP.
REQ-026 In RESP: rsp_valid=1 and rsp_rdata stable until the rsp_valid&rsp_ready edge, then ->IDLE; rsp_ready is ignored outside RESP.
REQ-027 Latency with ACCESS_CYCLES=2, accept at edge 0: SETUP cycle 1, ACCESS cycles 2-3, HOLD cycle 4; read rsp_valid from cycle 5; after a write, req_ready=1 in cycle 5.
REQ-028 Back-to-back throughput SHALL be one request per ACCESS_CYCLES+3 cycles (writes) or +4 minimum (reads).
REQ-029 A request held while req_ready=0 SHALL NOT be accepted or lost; the requester keeps it until accepted.
REQ-030 In IDLE, arr_rw SHALL be 0 and arr_wdata SHALL hold its last value.
REQ-031 A write SHALL produce no response.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, arr_wordline=0, arr_rw=0, arr_wdata=0, rsp_valid=0, rsp_rdata=0, counter=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation and force arr_wordline=0 immediately, without waiting for a clock edge; the aborted write's array content is undefined.
REQ-034 After rst_n rises, req_ready SHALL be 1 in the first cycle.

Structure
REQ-035 Shared package sram_pkg SHALL hold the state encoding constants and the default DATA_W/ADDR_W.
REQ-036 Sub-module addr_decoder SHALL map ADDR_W bits plus an enable to a one-hot 2**ADDR_W vector; the controller instantiates it once.
REQ-037 The bench SHALL connect sram_ctrl to the existing 8x8 grid array model.

Verification
REQ-038 Write 42 to addr 0, then read addr 0 -> rsp_rdata=42, arr_wordline=8'b00000001 only in the 2 ACCESS cycles.
REQ-039 Writes 255->1, 69->3, 127->7, then read all 0..7 -> words 1/3/7 return 255/69/127, and each wordline pulse is one-hot.
REQ-040 Read addr 3 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1, rsp_rdata stays 69, req_ready=0; IDLE the cycle after rsp_ready=1.
REQ-041 req_valid held high during a write's ACCESS -> second request is accepted only at the cycle-5 edge, with its addr/data intact.
REQ-042 rst_n pulled low in the 2nd ACCESS cycle of a write -> arr_wordline=0 before the next edge, all outputs at reset values, req_ready=1 after release.
REQ-043 Sweep ACCESS_CYCLES in {1,4} -> the ACCESS pulse width equals the parameter and the REQ-027 timings scale accordingly.
